// File: rtl/v_pkg.sv
// Shared vector-issue definitions: opcode constants, queue entry layout, opcode classifiers.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package v_pkg;

  localparam int V_XLEN = 32;

  localparam logic [6:0] OPC_LTYPE = 7'b0000111;  // vector load
  localparam logic [6:0] OPC_STYPE = 7'b0100111;  // vector store
  localparam logic [6:0] OPC_RTYPE = 7'b1010111;  // OP-V
  localparam logic [2:0] OP_SET    = 3'b111;      // funct3 of vsetvl-class under OP-V

  typedef struct packed {
    logic [31:0]       instr;
    logic [V_XLEN-1:0] rs1;
    logic [V_XLEN-1:0] rs2;
  } v_issue_entry_t;

  function automatic logic is_v_opcode(input logic [6:0] opc);
    return (opc == OPC_LTYPE) || (opc == OPC_STYPE) || (opc == OPC_RTYPE);
  endfunction

  function automatic logic is_vconfig(input logic [31:0] instr);
    return (instr[6:0] == OPC_RTYPE) && (instr[14:12] == OP_SET);
  endfunction

endpackage

// File: rtl/v_fifo_mem.sv
// DEPTH x W register-file storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the owner decides when to write.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module v_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are never reset; occupancy tracking in the owner masks stale data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/v_issue_queue.sv
// In-order buffer of vector instructions + scalar operands between core dispatch and vector decode.
// Latency: an accepted entry reaches the outputs one cycle later at the earliest (no fall-through).
// Backpressure: in_ready drops at full; issue stalls after a vconfig pops until cfg_done.
// Ports: clk/rst/flush; in_* push side; out_* issue side; cfg_done/cfg_wait barrier;
//        illegal pulse for rejected opcodes; count = occupancy.
module v_issue_queue
  import v_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  input  logic            cfg_done,
  output logic            cfg_wait,
  output logic            illegal,
  output logic [CW-1:0]   count
);

  localparam int EW = 32 + 2 * XLEN;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [EW-1:0] head;
  logic          accept, legal, push, pop, empty;

  assign empty     = (count == '0);
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = !empty && !cfg_wait;

  assign accept = in_valid && in_ready;
  assign legal  = is_v_opcode(in_instr[6:0]);
  // Flush overrides the handshakes: nothing is stored or consumed that cycle.
  assign push   = accept && legal && !flush;
  assign pop    = out_valid && out_ready && !flush;

  v_fifo_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_instr, in_rs1, in_rs2}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Storage is unreset, so blank the outputs while empty.
  assign out_instr = empty ? '0 : head[EW-1 -: 32];
  assign out_rs1   = empty ? '0 : head[2*XLEN-1 -: XLEN];
  assign out_rs2   = empty ? '0 : head[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cfg_wait <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      // Reject is reported even when a flush lands in the same cycle.
      illegal <= accept && !legal;
      if (flush) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        cfg_wait <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;  // DEPTH is a power of two: wrap is free
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        // pop implies !cfg_wait, so setting and clearing never collide;
        // a cfg_done coinciding with the vconfig pop is therefore ignored.
        if (cfg_wait && cfg_done)
          cfg_wait <= 1'b0;
        else if (pop && is_vconfig(head[EW-1 -: 32]))
          cfg_wait <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_v_issue_queue.sv
module tb_v_issue_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [31:0] VADD  = 32'h022180D7;
  localparam logic [31:0] VSETV = 32'h010572D7;
  localparam logic [31:0] ADDI  = 32'h00000013;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic            cfg_done, cfg_wait, illegal;
  logic [31:0]     in_instr, out_instr;
  logic [XLEN-1:0] in_rs1, in_rs2, out_rs1, out_rs2;
  logic [CW-1:0]   count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  v_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_rs1   (out_rs1),
    .out_rs2   (out_rs2),
    .cfg_done  (cfg_done),
    .cfg_wait  (cfg_wait),
    .illegal   (illegal),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set after this return are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] r1,
                       input logic [XLEN-1:0] r2);
    in_valid = v;
    in_instr = ins;
    in_rs1   = r1;
    in_rs2   = r2;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; cfg_done = 1'b0;
    drive(1'b0, '0, '0, '0);

    // Reset
    step(); step();
    rst = 1'b0;
    chk("rst_count", 64'(count), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_cfg_wait", 64'(cfg_wait), 0);
    chk("rst_illegal", 64'(illegal), 0);
    chk("rst_out_instr", 64'(out_instr), 0);

    // Fill to DEPTH, then a fifth push must be refused
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, VADD, 32'(i), 32'(100 + i));
      step();
    end
    chk("fill_count", 64'(count), 4);
    chk("fill_in_ready", 64'(in_ready), 0);
    drive(1'b1, VADD, 32'h99, 32'h99);
    step();
    drive(1'b0, '0, '0, '0);
    chk("full_no_push_count", 64'(count), 4);
    chk("full_head_rs1", 64'(out_rs1), 0);

    // Drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(out_valid), 1);
      chk("drain_rs1", 64'(out_rs1), 64'(i));
      chk("drain_rs2", 64'(out_rs2), 64'(100 + i));
      chk("drain_instr", 64'(out_instr), 64'(VADD));
      step();
    end
    out_ready = 1'b0;
    chk("drain_count", 64'(count), 0);
    chk("drain_out_valid", 64'(out_valid), 0);
    chk("drain_out_instr_zero", 64'(out_instr), 0);

    // Concurrent push/pop at count=2 across pointer wrap
    drive(1'b1, VADD, 32'd10, 32'd0); step();
    drive(1'b1, VADD, 32'd11, 32'd0); step();
    chk("conc_pre_count", 64'(count), 2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, VADD, 32'(12 + k), 32'd0);
      chk("conc_head_rs1", 64'(out_rs1), 64'(10 + k));
      step();
      chk("conc_count", 64'(count), 2);
    end
    drive(1'b0, '0, '0, '0);
    chk("conc_tail0", 64'(out_rs1), 20);
    step();
    chk("conc_tail1", 64'(out_rs1), 21);
    step();
    out_ready = 1'b0;
    chk("conc_end_count", 64'(count), 0);

    // Config barrier; cfg_done in the pop cycle is ignored
    drive(1'b1, VSETV, 32'h55, 32'd0); step();
    drive(1'b1, VADD, 32'h66, 32'd0); step();
    drive(1'b0, '0, '0, '0);
    chk("cfg_head_instr", 64'(out_instr), 64'(VSETV));
    chk("cfg_head_valid", 64'(out_valid), 1);
    out_ready = 1'b1;
    cfg_done  = 1'b1;
    step();
    cfg_done = 1'b0;
    chk("cfg_wait_set", 64'(cfg_wait), 1);
    chk("cfg_blocked_valid", 64'(out_valid), 0);
    chk("cfg_blocked_count", 64'(count), 1);
    chk("cfg_blocked_instr", 64'(out_instr), 64'(VADD));
    step();
    chk("cfg_still_wait", 64'(cfg_wait), 1);
    chk("cfg_still_count", 64'(count), 1);
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    chk("cfg_released", 64'(cfg_wait), 0);
    chk("cfg_vadd_valid", 64'(out_valid), 1);
    chk("cfg_vadd_rs1", 64'(out_rs1), 64'h66);
    step();
    out_ready = 1'b0;
    chk("cfg_end_count", 64'(count), 0);

    // Illegal opcode
    drive(1'b1, ADDI, 32'h1, 32'h2);
    step();
    drive(1'b0, '0, '0, '0);
    chk("ill_pulse", 64'(illegal), 1);
    chk("ill_count", 64'(count), 0);
    step();
    chk("ill_pulse_end", 64'(illegal), 0);

    // Flush while waiting on config, with a concurrent push
    drive(1'b1, VSETV, 32'h1, 32'd0); step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, VADD, 32'(2 + i), 32'd0);
      step();
    end
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    step();
    chk("fl_pre_wait", 64'(cfg_wait), 1);
    chk("fl_pre_count", 64'(count), 3);
    flush = 1'b1;
    drive(1'b1, VADD, 32'h77, 32'd0);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("fl_count", 64'(count), 0);
    chk("fl_cfg_wait", 64'(cfg_wait), 0);
    chk("fl_out_valid", 64'(out_valid), 0);
    chk("fl_in_ready", 64'(in_ready), 1);
    step();
    chk("fl_push_dropped", 64'(count), 0);

    // Reject coinciding with flush is still reported
    flush = 1'b1;
    drive(1'b1, ADDI, 32'd0, 32'd0);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("fl_ill_pulse", 64'(illegal), 1);

    // Reset mid-operation drops everything
    out_ready = 1'b0;
    drive(1'b1, VADD, 32'h5, 32'd0); step();
    drive(1'b1, VADD, 32'h6, 32'd0); step();
    drive(1'b0, '0, '0, '0);
    chk("mid_pre_count", 64'(count), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_count", 64'(count), 0);
    chk("mid_rst_valid", 64'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
